fll_cfg_arbiter: RTL and testbench
==================================

FLL_CFG_ARBITER -- requirements
Module: fll_cfg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles spent in ISSUE or RELEASE before abort (range 2..65535).
REQ-002 SHALL have ports as follows; clock and reset first:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, synchronous, active-low.
- m0_req_i, m1_req_i  in  1  master config request; held until the matching ack_o.
- m0_wrn_i, m1_wrn_i  in  1  1=read, 0=write; stable while req high.
- m0_add_i, m1_add_i  in  2  FLL register address.
- m0_data_i, m1_data_i  in  32  write data.
- m0_ack_o, m1_ack_o  out  1  one-cycle completion pulse.
- m0_r_data_o, m1_r_data_o  out  32  read data, valid with ack_o.
- m0_err_o, m1_err_o  out  1  with ack_o, transaction aborted by timeout.
- fll_req_o  out  1  FLL config request.
- fll_wrn_o  out  1  FLL config direction.
- fll_add_o  out  2  FLL config address.
- fll_data_o  out  32  FLL config write data.
- fll_ack_i  in  1  FLL 4-phase acknowledge.
- fll_r_data_i  in  32  FLL read data.
- busy_o  out  1  FSM not in IDLE.
- timeout_o  out  1  sticky, any timeout occurred.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, RELEASE.
REQ-004 IDLE: if any req high, SHALL grant one master, register its wrn/add/data onto fll_*_o and enter ISSUE; fll_req_o rises the cycle after req is sampled.
REQ-005 Arbitration SHALL be round-robin: with both requesting, grant the master not served last; single requester always granted; after reset m0 has priority.
REQ-006 Last-served pointer SHALL update only on grant.
REQ-007 ISSUE: fll_req_o=1, fll_wrn_o/fll_add_o/fll_data_o held constant; on fll_ack_i=1, capture fll_r_data_i and enter RELEASE.
REQ-008 Entering RELEASE after ack, granted master's ack_o SHALL pulse exactly one cycle with r_data_o = captured data and err_o=0; the other master sees no ack.
REQ-009 RELEASE: fll_req_o=0; on fll_ack_i=0 SHALL return to IDLE; a new grant can occur in that IDLE cycle at the earliest.
REQ-010 A 16-bit cycle counter SHALL clear on every state entry and increment each cycle in ISSUE/RELEASE.
REQ-011 ISSUE timeout (counter reaches TIMEOUT_CYC-1 with no ack): SHALL enter RELEASE, pulse ack_o with err_o=1 and r_data_o=32'h0, and set timeout_o.
REQ-012 RELEASE timeout (fll_ack_i still high): SHALL force IDLE and set timeout_o; no extra master ack.
REQ-013 r_data_o SHALL hold its last value between acks; err_o SHALL be 0 whenever ack_o=0.
REQ-014 ack_o seen in IDLE the same cycle as fll_ack_i rises SHALL be impossible; fll_ack_i in IDLE SHALL be ignored.
REQ-015 A req that drops before its ack SHALL NOT abort an issued transaction; completion still pulses ack_o.
REQ-016 Writes SHALL also complete via REQ-008; r_data_o then carries fll_r_data_i as sampled.
REQ-017 Served master SHALL deassert req in the cycle after ack_o; the arbiter relies on RELEASE lasting at least 1 cycle to avoid a double grant.

Reset
REQ-018 With rst_ni=0 at a clk_i edge: state=IDLE, counter=0, pointer=m1, timeout_o=0, busy_o=0, fll_req_o=0, fll_wrn_o=1, fll_add_o=0, fll_data_o=0, all ack_o/err_o=0, r_data_o=0.
REQ-019 Reset mid-ISSUE SHALL drop fll_req_o on the next edge with no master ack; after release, the FSM waits in IDLE; fll_ack_i is ignored there.

Verification
REQ-020 m0 write add=2 data=32'h0000_ABCD; FLL acks 3 cycles later, drops ack 2 cycles after req falls -> fll_req_o high 1 cycle after req, fll_data_o stable, m0_ack_o single pulse, busy_o low after ack falls.
REQ-021 m0 and m1 reads requested simultaneously after reset, fll_r_data_i=32'h1111/32'h2222 -> m0 served first with 32'h1111, then m1 with 32'h2222; repeated simultaneous requests alternate.
REQ-022 m1 only, 4 back-to-back reads -> m1 granted every time, no m0 ack.
REQ-023 TIMEOUT_CYC=8, FLL never acks -> fll_req_o high exactly 8 cycles, m0_ack_o with m0_err_o=1, r_data_o=0, timeout_o=1 sticky until reset.
REQ-024 fll_ack_i stuck high after ack, TIMEOUT_CYC=8 -> IDLE after 8 RELEASE cycles, timeout_o=1, single master ack only.
REQ-025 rst_ni low for 1 cycle mid-ISSUE -> fll_req_o=0 next edge, no ack_o, all REQ-018 values, next request served normally.

Source files
------------

// File: rtl/fll_cfg_arbiter.sv
// fll_cfg_arbiter: shares one FLL configuration port between two masters.
// Round-robin grant, 4-phase handshake to the FLL, and a cycle-counter
// timeout that aborts a hung ISSUE or RELEASE phase.
//
// Handshakes:
//  - Master side: mX_req_i is raised and held, with wrn/add/data stable,
//    until mX_ack_o pulses for one cycle. r_data_o/err_o are valid with that
//    pulse. The master drops req in the cycle after the pulse.
//  - FLL side: fll_req_o rises, fll_ack_i rises, fll_req_o falls, and then
//    fll_ack_i falls. fll_r_data_i is sampled on the cycle fll_ack_i is seen high.
module fll_cfg_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_wrn_i,
  input  logic        m1_wrn_i,
  input  logic [1:0]  m0_add_i,
  input  logic [1:0]  m1_add_i,
  input  logic [31:0] m0_data_i,
  input  logic [31:0] m1_data_i,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic [31:0] m0_r_data_o,
  output logic [31:0] m1_r_data_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_ISSUE   = 2'd1;
  localparam logic [1:0]  ST_RELEASE = 2'd2;
  localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_q, last_d;      // master served last: 0 = m0, 1 = m1
  logic        gnt_q, gnt_d;        // master owning the current transaction
  logic        gnt_sel;
  logic        fll_req_q, fll_req_d;
  logic        fll_wrn_q, fll_wrn_d;
  logic [1:0]  fll_add_q, fll_add_d;
  logic [31:0] fll_data_q, fll_data_d;
  logic [1:0]  ack_q, ack_d;        // bit index = master
  logic [1:0]  err_q, err_d;
  logic [31:0] r_data0_q, r_data0_d;
  logic [31:0] r_data1_q, r_data1_d;
  logic        timeout_q, timeout_d;

  // Next-state logic: arbitration, FLL handshake sequencing and timeouts.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    gnt_sel    = 1'b0;
    fll_req_d  = fll_req_q;
    fll_wrn_d  = fll_wrn_q;
    fll_add_d  = fll_add_q;
    fll_data_d = fll_data_q;
    ack_d      = 2'b00;
    err_d      = 2'b00;
    r_data0_d  = r_data0_q;
    r_data1_d  = r_data1_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        // fll_ack_i is deliberately not looked at here.
        if (m0_req_i || m1_req_i) begin
          gnt_sel    = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
          gnt_d      = gnt_sel;
          last_d     = gnt_sel;
          fll_wrn_d  = gnt_sel ? m1_wrn_i : m0_wrn_i;
          fll_add_d  = gnt_sel ? m1_add_i : m0_add_i;
          fll_data_d = gnt_sel ? m1_data_i : m0_data_i;
          fll_req_d  = 1'b1;
          cnt_d      = 16'd0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (fll_ack_i) begin
          fll_req_d = 1'b0;
          cnt_d     = 16'd0;
          state_d   = ST_RELEASE;
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          if (gnt_q) r_data1_d = fll_r_data_i;
          else       r_data0_d = fll_r_data_i;
        end else if (cnt_q == CNT_LAST) begin
          fll_req_d = 1'b0;
          cnt_d     = 16'd0;
          state_d   = ST_RELEASE;
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          err_d     = gnt_q ? 2'b10 : 2'b01;
          timeout_d = 1'b1;
          if (gnt_q) r_data1_d = 32'h0;
          else       r_data0_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (!fll_ack_i) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = 16'd0;
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d     = 16'd0;
        fll_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      fll_req_q  <= 1'b0;
      fll_wrn_q  <= 1'b1;
      fll_add_q  <= 2'd0;
      fll_data_q <= 32'h0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      r_data0_q  <= 32'h0;
      r_data1_q  <= 32'h0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      fll_req_q  <= fll_req_d;
      fll_wrn_q  <= fll_wrn_d;
      fll_add_q  <= fll_add_d;
      fll_data_q <= fll_data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      r_data0_q  <= r_data0_d;
      r_data1_q  <= r_data1_d;
      timeout_q  <= timeout_d;
    end
  end

  assign m0_ack_o    = ack_q[0];
  assign m1_ack_o    = ack_q[1];
  assign m0_err_o    = err_q[0];
  assign m1_err_o    = err_q[1];
  assign m0_r_data_o = r_data0_q;
  assign m1_r_data_o = r_data1_q;
  assign fll_req_o   = fll_req_q;
  assign fll_wrn_o   = fll_wrn_q;
  assign fll_add_o   = fll_add_q;
  assign fll_data_o  = fll_data_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// tb_fll_cfg_arbiter: transaction-level reference model for the FLL config
// arbiter. Each transaction is laid out as a window timeline computed from
// the grant/ack/release rules, one expected record per clock window.
module tb_fll_cfg_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i, m0_wrn_i, m1_wrn_i;
  logic [1:0]  m0_add_i, m1_add_i;
  logic [31:0] m0_data_i, m1_data_i;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] m0_r_data_o, m1_r_data_o;
  logic        fll_req_o, fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i;
  logic [31:0] fll_r_data_i;
  logic        busy_o, timeout_o;

  fll_cfg_arbiter #(.TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_wrn_i(m0_wrn_i), .m1_wrn_i(m1_wrn_i),
    .m0_add_i(m0_add_i), .m1_add_i(m1_add_i),
    .m0_data_i(m0_data_i), .m1_data_i(m1_data_i),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .m0_r_data_o(m0_r_data_o), .m1_r_data_o(m1_r_data_o),
    .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o),
    .fll_add_o(fll_add_o), .fll_data_o(fll_data_o),
    .fll_ack_i(fll_ack_i), .fll_r_data_i(fll_r_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, freq, a0, a1, e0, e1, tmo, chk_f, wrn;
    logic [1:0]  add;
    logic [31:0] data, r0, r1;
  } exp_t;
  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_r [2];
  logic        m_tmo;
  int          last_srv;
  // Per-master transaction parameters
  logic        p_wrn  [2];
  logic [1:0]  p_add  [2];
  logic [31:0] p_data [2];
  logic [31:0] p_rd   [2];
  int          p_d    [2];   // FLL ack delay after req visible, -1 = never
  int          p_r    [2];   // FLL ack hold after req drop, -1 = stuck
  bit          p_early[2];   // master drops req before its ack

  // Observation of DUT behaviour for literal checks
  int req_run = 0, last_req_run = 0, busy_run = 0, last_busy_run = 0;
  int n_ack0 = 0, n_ack1 = 0;
  int ack_log[$];
  int err_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic busy, input logic freq, input int ack_m,
                              input logic err, input int fm);
    exp_t e;
    e      = '0;
    e.busy = busy;
    e.freq = freq;
    e.a0   = (ack_m == 0);
    e.a1   = (ack_m == 1);
    e.e0   = (ack_m == 0) && err;
    e.e1   = (ack_m == 1) && err;
    e.tmo  = m_tmo;
    e.r0   = m_r[0];
    e.r1   = m_r[1];
    if (fm == 0 || fm == 1) begin
      e.chk_f = 1'b1; e.wrn = p_wrn[fm]; e.add = p_add[fm]; e.data = p_data[fm];
    end else if (fm == 2) begin
      e.chk_f = 1'b1; e.wrn = 1'b1; e.add = 2'd0; e.data = 32'h0;
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int g, input logic v);
    if (g == 0) m0_req_i = v;
    else        m1_req_i = v;
  endtask

  task automatic model_reset();
    m_r[0] = 32'h0; m_r[1] = 32'h0; m_tmo = 1'b0; last_srv = 1;
  endtask

  // One granted transaction; starts in the window after its req is sampled.
  task automatic run_txn(input int g);
    int  e_end, m;
    bit  timed, stuck;
    timed = (p_d[g] < 0);
    stuck = !timed && (p_r[g] < 0);
    e_end = timed ? T : p_d[g] + 1;
    m     = timed ? 1 : (stuck ? T : p_r[g] + 1);
    for (int k = 1; k <= e_end; k++) begin
      tick();
      fll_ack_i    = !timed && (k == e_end);
      fll_r_data_i = p_rd[g];
      if (p_early[g] && k == 2) set_req(g, 1'b0);
      step(mk(1'b1, 1'b1, -1, 1'b0, g));
    end
    tick();
    fll_ack_i = !timed && (stuck || p_r[g] >= 1);
    m_r[g] = timed ? 32'h0 : p_rd[g];
    if (timed) m_tmo = 1'b1;
    step(mk(1'b1, 1'b0, g, timed, -1));
    for (int k = 2; k <= m; k++) begin
      tick();
      set_req(g, 1'b0);
      fll_ack_i = stuck || (k <= p_r[g]);
      step(mk(1'b1, 1'b0, -1, 1'b0, -1));
    end
    tick();
    set_req(g, 1'b0);
    fll_ack_i = stuck;           // lingering ack in IDLE must be ignored
    if (stuck) m_tmo = 1'b1;
    step(mk(1'b0, 1'b0, -1, 1'b0, -1));
    last_srv = g;
  endtask

  task automatic run_round(input bit w0, input bit w1);
    int first;
    tick();
    m0_wrn_i = p_wrn[0]; m0_add_i = p_add[0]; m0_data_i = p_data[0];
    m1_wrn_i = p_wrn[1]; m1_add_i = p_add[1]; m1_data_i = p_data[1];
    m0_req_i = w0; m1_req_i = w1;
    fll_ack_i = 1'b0;
    step(mk(1'b0, 1'b0, -1, 1'b0, -1));
    first = (w0 && w1) ? ((last_srv == 0) ? 1 : 0) : (w1 ? 1 : 0);
    run_txn(first);
    if (w0 && w1) run_txn(1 - first);
  endtask

  task automatic settle();
    tick();
    fll_ack_i = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;
    step(mk(1'b0, 1'b0, -1, 1'b0, -1));
    #3;
  endtask

  task automatic rand_txn(input int g);
    int sel;
    p_wrn[g]  = 1'($urandom_range(0, 1));
    p_add[g]  = 2'($urandom_range(0, 3));
    p_data[g] = $urandom;
    p_rd[g]   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 7)       p_d[g] = $urandom_range(0, 4);
    else if (sel == 7) p_d[g] = T - 1;
    else if (sel == 8) p_d[g] = -1;
    else               p_d[g] = $urandom_range(0, T - 1);
    p_r[g]     = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
    p_early[g] = ($urandom_range(0, 4) == 0);
  endtask

  // Compare process: checks every recorded window, tracks run lengths.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy",      32'(busy_o),      32'(e.busy));
        chk("fll_req",   32'(fll_req_o),   32'(e.freq));
        chk("m0_ack",    32'(m0_ack_o),    32'(e.a0));
        chk("m1_ack",    32'(m1_ack_o),    32'(e.a1));
        chk("m0_err",    32'(m0_err_o),    32'(e.e0));
        chk("m1_err",    32'(m1_err_o),    32'(e.e1));
        chk("timeout",   32'(timeout_o),   32'(e.tmo));
        chk("m0_r_data", m0_r_data_o,      e.r0);
        chk("m1_r_data", m1_r_data_o,      e.r1);
        if (e.chk_f) begin
          chk("fll_wrn",  32'(fll_wrn_o),  32'(e.wrn));
          chk("fll_add",  32'(fll_add_o),  32'(e.add));
          chk("fll_data", fll_data_o,      e.data);
        end
      end
      if (fll_req_o === 1'b1) req_run++;
      else if (req_run != 0) begin last_req_run = req_run; req_run = 0; end
      if (busy_o === 1'b1) busy_run++;
      else if (busy_run != 0) begin last_busy_run = busy_run; busy_run = 0; end
      if (m0_ack_o === 1'b1) begin n_ack0++; ack_log.push_back(0); err_log.push_back(int'(m0_err_o)); end
      if (m1_ack_o === 1'b1) begin n_ack1++; ack_log.push_back(1); err_log.push_back(int'(m1_err_o)); end
    end
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Main stimulus
  initial begin
    int base, a0b, a1b;
    rst_ni = 1'b0;
    m0_req_i = 1'b0; m1_req_i = 1'b0; m0_wrn_i = 1'b0; m1_wrn_i = 1'b0;
    m0_add_i = '0; m1_add_i = '0; m0_data_i = '0; m1_data_i = '0;
    fll_ack_i = 1'b0; fll_r_data_i = '0;
    for (int g = 0; g < 2; g++) begin
      p_wrn[g] = 1'b0; p_add[g] = '0; p_data[g] = '0; p_rd[g] = '0;
      p_d[g] = 0; p_r[g] = 0; p_early[g] = 1'b0;
    end
    model_reset();

    // Reset: values after the first sampled edge
    tick();
    tick(); step(mk(1'b0, 1'b0, -1, 1'b0, 2));
    tick(); step(mk(1'b0, 1'b0, -1, 1'b0, 2));
    #3;
    chk("reset_fll_wrn",  32'(fll_wrn_o), 32'd1);
    chk("reset_fll_req",  32'(fll_req_o), 32'd0);
    chk("reset_busy",     32'(busy_o),    32'd0);
    tick(); rst_ni = 1'b1; step(mk(1'b0, 1'b0, -1, 1'b0, 2));

    // Simultaneous reads after reset: m0 first, then alternation
    for (int g = 0; g < 2; g++) begin
      p_wrn[g] = 1'b1; p_add[g] = 2'(g + 1); p_data[g] = 32'h0;
      p_d[g] = g + 1; p_r[g] = 0; p_early[g] = 1'b0;
    end
    p_rd[0] = 32'h1111; p_rd[1] = 32'h2222;
    base = ack_log.size();
    run_round(1'b1, 1'b1);
    run_round(1'b1, 1'b1);
    settle();
    chk("rr_ack_count", 32'(ack_log.size() - base), 32'd4);
    if (ack_log.size() >= base + 4) begin
      chk("rr_order_0", 32'(ack_log[base]),     32'd0);
      chk("rr_order_1", 32'(ack_log[base + 1]), 32'd1);
      chk("rr_order_2", 32'(ack_log[base + 2]), 32'd0);
      chk("rr_order_3", 32'(ack_log[base + 3]), 32'd1);
    end
    chk("rr_m0_rdata", m0_r_data_o, 32'h1111);
    chk("rr_m1_rdata", m1_r_data_o, 32'h2222);

    // m0 write, FLL acks 3 cycles after req, drops ack 2 cycles after req falls
    p_wrn[0] = 1'b0; p_add[0] = 2'd2; p_data[0] = 32'h0000_ABCD; p_rd[0] = 32'h5A5A_0001;
    p_d[0] = 3; p_r[0] = 2; p_early[0] = 1'b0;
    a0b = n_ack0;
    run_round(1'b1, 1'b0);
    settle();
    chk("wr_req_run",  32'(last_req_run),  32'd4);
    chk("wr_busy_run", 32'(last_busy_run), 32'd7);
    chk("wr_ack_cnt",  32'(n_ack0 - a0b),  32'd1);
    chk("wr_rdata",    m0_r_data_o,        32'h5A5A_0001);

    // m1 only, four back-to-back reads
    a0b = n_ack0; a1b = n_ack1;
    for (int i = 0; i < 4; i++) begin
      rand_txn(1);
      p_wrn[1] = 1'b1; p_d[1] = $urandom_range(0, 4); p_r[1] = $urandom_range(0, 3);
      run_round(1'b0, 1'b1);
    end
    settle();
    chk("m1only_m0_acks", 32'(n_ack0 - a0b), 32'd0);
    chk("m1only_m1_acks", 32'(n_ack1 - a1b), 32'd4);

    // ISSUE timeout: FLL never acks
    rand_txn(0); p_d[0] = -1; p_r[0] = 0; p_early[0] = 1'b0;
    run_round(1'b1, 1'b0);
    settle();
    chk("to_req_run", 32'(last_req_run), 32'd8);
    chk("to_sticky",  32'(timeout_o),    32'd1);
    chk("to_rdata",   m0_r_data_o,       32'h0);
    if (err_log.size() > 0) chk("to_err", 32'(err_log[err_log.size() - 1]), 32'd1);
    else chk("to_err_seen", 32'(err_log.size()), 32'd1);

    // RELEASE timeout: ack stuck high
    rand_txn(0); p_d[0] = 1; p_r[0] = -1; p_early[0] = 1'b0;
    a0b = n_ack0;
    run_round(1'b1, 1'b0);
    settle();
    chk("rel_busy_run", 32'(last_busy_run), 32'd10);
    chk("rel_acks",     32'(n_ack0 - a0b),  32'd1);
    chk("rel_sticky",   32'(timeout_o),     32'd1);

    // One-cycle reset mid-ISSUE
    rand_txn(0); p_d[0] = -1;
    a0b = n_ack0;
    tick();
    m0_wrn_i = p_wrn[0]; m0_add_i = p_add[0]; m0_data_i = p_data[0];
    m0_req_i = 1'b1; fll_ack_i = 1'b0;
    step(mk(1'b0, 1'b0, -1, 1'b0, -1));
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) rst_ni = 1'b0;
      step(mk(1'b1, 1'b1, -1, 1'b0, 0));
    end
    model_reset();
    tick(); rst_ni = 1'b1; m0_req_i = 1'b0; fll_ack_i = 1'b1; step(mk(1'b0, 1'b0, -1, 1'b0, 2));
    tick(); fll_ack_i = 1'b1; step(mk(1'b0, 1'b0, -1, 1'b0, 2));
    tick(); fll_ack_i = 1'b0; step(mk(1'b0, 1'b0, -1, 1'b0, 2));
    #3;
    chk("rst_no_ack", 32'(n_ack0 - a0b), 32'd0);
    rand_txn(0); p_d[0] = 2; p_r[0] = 1; p_early[0] = 1'b0;
    run_round(1'b1, 1'b0);
    settle();
    chk("post_rst_ack", 32'(n_ack0 - a0b), 32'd1);
    chk("post_rst_rd",  m0_r_data_o,       p_rd[0]);

    // Randomized rounds
    for (int i = 0; i < 40; i++) begin
      int sel;
      rand_txn(0);
      rand_txn(1);
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1]);
      if ($urandom_range(0, 2) == 0) settle();
    end
    settle();
    tick();
    tick();
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
